// File: rtl/cordic_pkg.sv
// Shared constants and types for the Cordic phase source: angle scaling,
// quadrant encoding, dither LFSR taps/seed and the start-vector amplitude clamp.
package cordic_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        Q3 = 2'b11
    } quadrant_e;

    localparam int unsigned PH_BITS_DEF = 16;
    localparam int unsigned XY_BITS_DEF = 16;

    localparam logic [PH_BITS_DEF-1:0] ANGLE_180 = 16'h8000;
    localparam logic [PH_BITS_DEF-1:0] ANGLE_90  = 16'h4000;
    localparam logic [XY_BITS_DEF-1:0] AMP_MAX   = 16'h7FFF;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [63:0] angle_180(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] angle_90(input int unsigned w);
        return 64'd1 << (w - 2);
    endfunction

    function automatic logic [63:0] amp_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/cordic_phase_fold.sv
// Folds a full-circle phase into the Cordic's +/-90 degree convergence range by
// rotating the start vector through 180 degrees for the two left-half quadrants.
module cordic_phase_fold #(
    parameter int PH_BITS = 16,
    parameter int XY_BITS = 16
) (
    input  logic [PH_BITS-1:0] p,
    input  logic [XY_BITS-1:0] amp,
    output logic [PH_BITS-1:0] phase_out,
    output logic [XY_BITS-1:0] x_out,
    output logic [XY_BITS-1:0] y_out
);
    import cordic_pkg::*;

    localparam logic [PH_BITS-1:0] HALF_TURN = PH_BITS'(angle_180(PH_BITS));

    quadrant_e quad;

    always_comb begin
        quad      = quadrant_e'(p[PH_BITS-1 -: 2]);
        phase_out = p;
        x_out     = amp;
        y_out     = '0;
        // +90 exactly sits in Q1 and folds to -90 with a negated vector
        if (quad == Q1 || quad == Q2) begin
            phase_out = p + HALF_TURN;
            x_out     = -amp;
        end
    end

endmodule

// File: rtl/cordic_nco_driver.sv
// Phase-accumulator NCO feeding the Cordic rotator, with shadowed configuration
// and a sample-rate divider. Define NCO_PHASE_DITHER_EN to add LFSR phase dither.
module cordic_nco_driver #(
    parameter int ACC_BITS = 32,
    parameter int PH_BITS  = 16,
    parameter int XY_BITS  = 16,
    parameter int DIV_BITS = 8
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [ACC_BITS-1:0] cfg_ftw,
    input  logic [ACC_BITS-1:0] cfg_poff,
    input  logic [XY_BITS-1:0]  cfg_amp,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic                cfg_sync,
    output logic                cfg_pending,
    output logic [XY_BITS-1:0]  x_i,
    output logic [XY_BITS-1:0]  y_i,
    output logic [PH_BITS-1:0]  phase_in,
    output logic                valid_in
);
    import cordic_pkg::*;

    localparam logic [XY_BITS-1:0] AMP_CLAMP = XY_BITS'(amp_max(XY_BITS));

    typedef struct packed {
        logic [ACC_BITS-1:0] ftw;
        logic [ACC_BITS-1:0] poff;
        logic [XY_BITS-1:0]  amp;
        logic [DIV_BITS-1:0] div;
    } cfg_t;

    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    cfg_t                act_q, act_d;
    cfg_t                shd_q, shd_d;
    logic                shd_sync_q, shd_sync_d;
    logic                pend_q, pend_d;
    logic [XY_BITS-1:0]  x_q, x_d;
    logic [XY_BITS-1:0]  y_q, y_d;
    logic [PH_BITS-1:0]  ph_q, ph_d;
    logic                valid_q, valid_d;

    logic                tick;
    logic                apply;
    logic [ACC_BITS-1:0] dither;
    logic [ACC_BITS-1:0] p_full;
    logic [PH_BITS-1:0]  p_trunc;
    logic [PH_BITS-1:0]  fold_ph;
    logic [XY_BITS-1:0]  fold_x;
    logic [XY_BITS-1:0]  fold_y;

    assign tick  = en && (cnt_q == act_q.div);
    // While idle the divider sits at 0, so a pending shadow lands without waiting
    assign apply = pend_q && (tick || (!en && cnt_q == '0));

`ifdef NCO_PHASE_DITHER_EN
    localparam int DITHER_BITS = ACC_BITS - PH_BITS;

    logic [15:0] lfsr_q, lfsr_d;

    generate
        if (DITHER_BITS >= 16) begin : g_dither_wide
            assign dither = ACC_BITS'(lfsr_q);
        end else begin : g_dither_narrow
            assign dither = ACC_BITS'(lfsr_q[DITHER_BITS-1:0]);
        end
    endgenerate

    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dither = '0;
`endif

    assign p_full  = acc_q + act_q.poff + dither;
    assign p_trunc = p_full[ACC_BITS-1 -: PH_BITS];

    cordic_phase_fold #(
        .PH_BITS (PH_BITS),
        .XY_BITS (XY_BITS)
    ) u_fold (
        .p         (p_trunc),
        .amp       (act_q.amp),
        .phase_out (fold_ph),
        .x_out     (fold_x),
        .y_out     (fold_y)
    );

    always_comb begin
        acc_d      = acc_q;
        act_d      = act_q;
        shd_d      = shd_q;
        shd_sync_d = shd_sync_q;
        pend_d     = pend_q;
        x_d        = x_q;
        y_d        = y_q;
        ph_d       = ph_q;
        valid_d    = tick;
        cnt_d      = (!en || tick) ? '0 : cnt_q + DIV_BITS'(1);

        if (tick) begin
            acc_d = acc_q + act_q.ftw;
            x_d   = fold_x;
            y_d   = fold_y;
            ph_d  = fold_ph;
        end

        // Applying tick still used the old values above; new ones govern next tick
        if (apply) begin
            act_d  = shd_q;
            pend_d = 1'b0;
            if (shd_sync_q) begin
                acc_d = '0;
            end
        end

        if (cfg_we) begin
            shd_d.ftw  = cfg_ftw;
            shd_d.poff = cfg_poff;
            shd_d.amp  = cfg_amp[XY_BITS-1] ? AMP_CLAMP : cfg_amp;
            shd_d.div  = cfg_div;
            shd_sync_d = cfg_sync;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            act_q      <= '0;
            shd_q      <= '0;
            shd_sync_q <= 1'b0;
            pend_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            ph_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            shd_q      <= shd_d;
            shd_sync_q <= shd_sync_d;
            pend_q     <= pend_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ph_q       <= ph_d;
            valid_q    <= valid_d;
        end
    end

    assign cfg_pending = pend_q;
    assign x_i         = x_q;
    assign y_i         = y_q;
    assign phase_in    = ph_q;
    assign valid_in    = valid_q;

endmodule

// File: tb/tb_cordic_nco_driver.sv
// Randomised and directed bench for cordic_nco_driver against a behavioural
// phase-source model (default widths, dither off).
module tb_cordic_nco_driver;

    logic        clk = 1'b0;
    logic        RST;
    logic        en;
    logic        cfg_we;
    logic [31:0] cfg_ftw;
    logic [31:0] cfg_poff;
    logic [15:0] cfg_amp;
    logic [7:0]  cfg_div;
    logic        cfg_sync;
    logic        cfg_pending;
    logic [15:0] x_i;
    logic [15:0] y_i;
    logic [15:0] phase_in;
    logic        valid_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    cordic_nco_driver dut (
        .clk         (clk),
        .RST         (RST),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ftw     (cfg_ftw),
        .cfg_poff    (cfg_poff),
        .cfg_amp     (cfg_amp),
        .cfg_div     (cfg_div),
        .cfg_sync    (cfg_sync),
        .cfg_pending (cfg_pending),
        .x_i         (x_i),
        .y_i         (y_i),
        .phase_in    (phase_in),
        .valid_in    (valid_in)
    );

    // Reference model: angle accumulator plus active/pending settings
    bit [31:0] m_acc, m_ftw, m_poff, s_ftw, s_poff;
    bit [15:0] m_amp, s_amp, m_phase, m_x;
    bit [7:0]  m_div, s_div, m_cnt;
    bit        s_sync, m_pend, m_valid;

    logic [15:0] q_ph [4];
    logic [15:0] q_x  [4];

    task automatic model_clear();
        m_acc = 0; m_ftw = 0; m_poff = 0; s_ftw = 0; s_poff = 0;
        m_amp = 0; s_amp = 0; m_phase = 0; m_x = 0;
        m_div = 0; s_div = 0; m_cnt = 0;
        s_sync = 0; m_pend = 0; m_valid = 0;
    endtask

    // One clock: model consumes the inputs present at the edge, then #1 to sample
    task automatic step();
        bit        tick, apply;
        bit [15:0] p;
        bit [31:0] nacc;
        tick  = en && (m_cnt == m_div);
        apply = m_pend && (tick || (!en && m_cnt == 0));
        @(posedge clk);
        cyc++;
        if (RST) begin
            model_clear();
        end else begin
            m_valid = tick;
            nacc    = m_acc;
            if (tick) begin
                p = 16'((m_acc + m_poff) >> 16);
                if (p >= 16'h4000 && p < 16'hC000) begin
                    m_phase = p + 16'h8000;
                    m_x     = -m_amp;
                end else begin
                    m_phase = p;
                    m_x     = m_amp;
                end
                nacc = m_acc + m_ftw;
            end
            if (apply) begin
                m_ftw = s_ftw; m_poff = s_poff; m_amp = s_amp; m_div = s_div;
                m_pend = 0;
                if (s_sync) nacc = 0;
            end
            if (cfg_we) begin
                s_ftw  = cfg_ftw;
                s_poff = cfg_poff;
                s_amp  = (cfg_amp > 16'h7FFF) ? 16'h7FFF : cfg_amp;
                s_div  = cfg_div;
                s_sync = cfg_sync;
                m_pend = 1;
            end
            m_cnt = (!en || tick) ? 8'd0 : m_cnt + 8'd1;
            m_acc = nacc;
        end
        #1;
    endtask

    task automatic write_cfg(input bit [31:0] ftw, input bit [31:0] poff,
                             input bit [15:0] amp, input bit [7:0] div, input bit sync);
        cfg_ftw = ftw; cfg_poff = poff; cfg_amp = amp; cfg_div = div; cfg_sync = sync;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; en = 1'b0; cfg_we = 1'b0;
        cfg_ftw = 0; cfg_poff = 0; cfg_amp = 0; cfg_div = 0; cfg_sync = 0;
        repeat (2) step();
        RST = 1'b0;
        write_cfg(32'h1000_0000, 32'h0, 16'h2000, 8'd1, 1'b0);
        en = 1'b1;
        repeat (10) begin
            step();
            checks++;
            if ({cfg_pending, valid_in, phase_in, x_i, y_i} !== {m_pend, m_valid, m_phase, m_x, 16'h0}) begin
                errors++;
                $display("FAIL reset_run cyc=%0d got pend=%0b v=%0b ph=%h x=%h y=%h want pend=%0b v=%0b ph=%h x=%h y=0",
                         cyc, cfg_pending, valid_in, phase_in, x_i, y_i, m_pend, m_valid, m_phase, m_x);
            end
        end
        RST = 1'b1;
        step();
        cfg_ftw = 32'h1234_5678; cfg_amp = 16'h3333; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        step();
        RST = 1'b0;
        checks++;
        if ({x_i, y_i, phase_in, valid_in, cfg_pending} !== 50'h0) begin
            errors++;
            $display("FAIL reset_state got x=%h y=%h ph=%h v=%0b pend=%0b want all 0",
                     x_i, y_i, phase_in, valid_in, cfg_pending);
        end
        en = 1'b0;
        repeat (5) begin
            step();
            checks++;
            if (valid_in !== 1'b0 || cfg_pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet cyc=%0d got v=%0b pend=%0b want 0 0", cyc, valid_in, cfg_pending);
            end
        end
    endtask

    task automatic test_quarter_step();
        q_ph[0] = 16'h0000; q_x[0] = 16'h4000;
        q_ph[1] = 16'hC000; q_x[1] = 16'hC000;
        q_ph[2] = 16'h0000; q_x[2] = 16'hC000;
        q_ph[3] = 16'hC000; q_x[3] = 16'h4000;
        en = 1'b0;
        write_cfg(32'h4000_0000, 32'h0, 16'h4000, 8'd0, 1'b1);
        step();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({valid_in, phase_in, x_i} !== {1'b1, q_ph[i % 4], q_x[i % 4]}) begin
                errors++;
                $display("FAIL quarter_seq i=%0d got v=%0b ph=%h x=%h want v=1 ph=%h x=%h",
                         i, valid_in, phase_in, x_i, q_ph[i % 4], q_x[i % 4]);
            end
            checks++;
            if ({cfg_pending, valid_in, phase_in, x_i, y_i} !== {m_pend, m_valid, m_phase, m_x, 16'h0}) begin
                errors++;
                $display("FAIL quarter_model cyc=%0d got pend=%0b v=%0b ph=%h x=%h y=%h want pend=%0b v=%0b ph=%h x=%h y=0",
                         cyc, cfg_pending, valid_in, phase_in, x_i, y_i, m_pend, m_valid, m_phase, m_x);
            end
        end
    endtask

    task automatic test_divider();
        int        last_cyc;
        bit [15:0] last_ph;
        bit        have_last;
        write_cfg(32'h0100_0000, 32'h0, 16'h1234, 8'd3, 1'b1);
        step();
        have_last = 0;
        last_cyc  = 0;
        last_ph   = 0;
        repeat (40) begin
            step();
            checks++;
            if ({cfg_pending, valid_in, phase_in, x_i, y_i} !== {m_pend, m_valid, m_phase, m_x, 16'h0}) begin
                errors++;
                $display("FAIL divider_model cyc=%0d got pend=%0b v=%0b ph=%h x=%h y=%h want pend=%0b v=%0b ph=%h x=%h y=0",
                         cyc, cfg_pending, valid_in, phase_in, x_i, y_i, m_pend, m_valid, m_phase, m_x);
            end
            if (valid_in === 1'b1) begin
                if (have_last) begin
                    checks++;
                    if (cyc - last_cyc != 4 || phase_in !== last_ph + 16'h0100) begin
                        errors++;
                        $display("FAIL divider_step got gap=%0d ph=%h want gap=4 ph=%h",
                                 cyc - last_cyc, phase_in, last_ph + 16'h0100);
                    end
                end
                have_last = 1;
                last_cyc  = cyc;
                last_ph   = phase_in;
            end
        end
    endtask

    task automatic test_back_to_back_retune();
        bit [15:0] ph [5];
        bit        pend_seen [5];
        bit [15:0] want_step [4];
        int        n;
        int        budget;
        want_step[0] = 16'h0100; want_step[1] = 16'h0100;
        want_step[2] = 16'h0200; want_step[3] = 16'h0200;
        budget = 0;
        while (!(en && m_cnt == m_div) && budget < 10) begin
            step();
            budget++;
        end
        cfg_ftw = 32'h0200_0000; cfg_poff = 0; cfg_amp = 16'h1234; cfg_div = 8'd3; cfg_sync = 0;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        checks++;
        if (cfg_pending !== 1'b1 || valid_in !== 1'b1) begin
            errors++;
            $display("FAIL retune_load got pend=%0b v=%0b want pend=1 v=1", cfg_pending, valid_in);
        end
        ph[0] = phase_in;
        pend_seen[0] = cfg_pending;
        n = 1;
        budget = 0;
        while (n < 5 && budget < 40) begin
            step();
            budget++;
            checks++;
            if ({cfg_pending, valid_in, phase_in, x_i, y_i} !== {m_pend, m_valid, m_phase, m_x, 16'h0}) begin
                errors++;
                $display("FAIL retune_model cyc=%0d got pend=%0b v=%0b ph=%h x=%h y=%h want pend=%0b v=%0b ph=%h x=%h y=0",
                         cyc, cfg_pending, valid_in, phase_in, x_i, y_i, m_pend, m_valid, m_phase, m_x);
            end
            if (valid_in === 1'b1) begin
                ph[n] = phase_in;
                pend_seen[n] = cfg_pending;
                n++;
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL retune_timeout got %0d valids want 5", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ph[i + 1] - ph[i] !== want_step[i]) begin
                    errors++;
                    $display("FAIL retune_step i=%0d got %h want %h", i, ph[i + 1] - ph[i], want_step[i]);
                end
            end
            checks++;
            if (pend_seen[1] !== 1'b0) begin
                errors++;
                $display("FAIL retune_pending_clear got %0b want 0", pend_seen[1]);
            end
        end
    endtask

    task automatic test_sync_offset();
        int        budget;
        bit [15:0] last_ph;
        write_cfg(32'h0200_0000, 32'h2000_0000, 16'h1234, 8'd3, 1'b1);
        budget = 0;
        while (cfg_pending === 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        budget = 0;
        do begin
            step();
            budget++;
        end while (valid_in !== 1'b1 && budget < 10);
        checks++;
        if (valid_in !== 1'b1 || phase_in !== 16'h2000) begin
            errors++;
            $display("FAIL sync_phase got v=%0b ph=%h want v=1 ph=2000", valid_in, phase_in);
        end
        last_ph = phase_in;
        en = 1'b0;
        repeat (10) begin
            step();
            checks++;
            if (valid_in !== 1'b0 || phase_in !== last_ph) begin
                errors++;
                $display("FAIL sync_idle cyc=%0d got v=%0b ph=%h want v=0 ph=%h", cyc, valid_in, phase_in, last_ph);
            end
        end
        en = 1'b1;
        budget = 0;
        do begin
            step();
            budget++;
        end while (valid_in !== 1'b1 && budget < 10);
        checks++;
        if (valid_in !== 1'b1 || phase_in !== last_ph + 16'h0200) begin
            errors++;
            $display("FAIL sync_resume got v=%0b ph=%h want v=1 ph=%h", valid_in, phase_in, last_ph + 16'h0200);
        end
    endtask

    task automatic test_wrap_clamp();
        en = 1'b0;
        write_cfg(32'hFFFF_FFFF, 32'h0, 16'h9000, 8'd0, 1'b1);
        step();
        en = 1'b1;
        step();
        checks++;
        if ({valid_in, phase_in, x_i, y_i} !== {1'b1, 16'h0000, 16'h7FFF, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_first got v=%0b ph=%h x=%h y=%h want v=1 ph=0000 x=7fff y=0000",
                     valid_in, phase_in, x_i, y_i);
        end
        step();
        checks++;
        if ({valid_in, phase_in, x_i, y_i} !== {1'b1, 16'hFFFF, 16'h7FFF, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_second got v=%0b ph=%h x=%h y=%h want v=1 ph=ffff x=7fff y=0000",
                     valid_in, phase_in, x_i, y_i);
        end
    endtask

    task automatic test_random();
        repeat (1500) begin
            RST    = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 9) != 0);
            cfg_we = ($urandom_range(0, 24) == 0);
            cfg_ftw  = $urandom;
            cfg_poff = $urandom;
            cfg_amp  = 16'($urandom);
            cfg_div  = 8'($urandom_range(0, 3));
            cfg_sync = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if ({cfg_pending, valid_in, phase_in, x_i, y_i} !== {m_pend, m_valid, m_phase, m_x, 16'h0}) begin
                errors++;
                $display("FAIL random cyc=%0d got pend=%0b v=%0b ph=%h x=%h y=%h want pend=%0b v=%0b ph=%h x=%h y=0",
                         cyc, cfg_pending, valid_in, phase_in, x_i, y_i, m_pend, m_valid, m_phase, m_x);
            end
        end
        RST = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_quarter_step();
        test_divider();
        test_back_to_back_retune();
        test_sync_offset();
        test_wrap_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
